// File: rtl/object_cell_pkg.sv
// Shared widths and op encodings for the handle table and its object cells.
package object_cell_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int HNDL_WIDTH = 4;
  localparam int NUM_CELLS  = 4;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;

endpackage

// File: rtl/object_cell.sv
// One handle slot: allocation flag plus mapped base address. Cells chain via
// lower_free so the lowest-numbered free cell answers an allocation request.
module object_cell
  import object_cell_pkg::*;
#(
  parameter int ID         = 0,
  parameter int ADDR_WIDTH = object_cell_pkg::ADDR_WIDTH,
  parameter int HNDL_WIDTH = object_cell_pkg::HNDL_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [HNDL_WIDTH-1:0] i_chip_select,
  input  logic [ADDR_WIDTH-1:0] i_data,
  input  logic                  i_get_available_id,
  input  logic                  i_write_to_map,
  input  logic                  i_write_invalid,
  input  logic                  i_read_address,
  input  logic                  i_lower_free,
  output logic                  o_lower_free,
  output logic [ADDR_WIDTH-1:0] o_data,
  output logic                  o_data_en,
  output logic [ADDR_WIDTH-1:0] o_offset
);

  localparam logic [HNDL_WIDTH-1:0] ID_SEL  = HNDL_WIDTH'(ID);
  localparam logic [ADDR_WIDTH-1:0] ID_WORD = ADDR_WIDTH'(ID);

  logic                  alloc_q, alloc_d;
  logic [ADDR_WIDTH-1:0] base_q,  base_d;
  logic                  selected, free, winner;
  logic                  do_alloc, do_read;

  assign free     = ~alloc_q;
  assign selected = (i_chip_select == ID_SEL);
  assign winner   = free & ~i_lower_free;

  // Allocation yields to the higher-priority strobes so the returned ID
  // always matches a state change at the edge.
  assign do_alloc = i_get_available_id & winner & ~i_write_invalid & ~i_write_to_map;
  assign do_read  = i_read_address & selected & alloc_q;

  always_comb begin
    alloc_d = alloc_q;
    base_d  = base_q;
    if (i_write_invalid) begin
      if (selected) begin
        alloc_d = 1'b0;
        base_d  = '0;
      end
    end else if (i_write_to_map) begin
      if (selected && alloc_q) base_d = i_data;
    end else if (do_alloc) begin
      alloc_d = 1'b1;
      base_d  = '0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      alloc_q <= 1'b0;
      base_q  <= '0;
    end else begin
      alloc_q <= alloc_d;
      base_q  <= base_d;
    end
  end

  // Outputs are zero when idle so the parent can OR cells together; reset
  // masks them because a strobe arriving during reset must be lost.
  always_comb begin
    o_data    = '0;
    o_data_en = 1'b0;
    if (i_reset_n) begin
      if (do_read) begin
        o_data    = base_q;
        o_data_en = 1'b1;
      end else if (do_alloc) begin
        o_data    = ID_WORD;
        o_data_en = 1'b1;
      end
    end
  end

  assign o_offset     = (selected && alloc_q) ? base_q : '0;
  assign o_lower_free = i_lower_free | free;

endmodule

// File: tb/tb_object_cell.sv
// Four-cell chain of object_cell with OR-combined outputs, driven by directed vectors.
module tb_object_cell;
  import object_cell_pkg::*;

  localparam int N = 4;

  logic                  clk, rst_n;
  logic [HNDL_WIDTH-1:0] sel;
  logic [ADDR_WIDTH-1:0] din;
  logic                  get_id, wr_map, wr_inv, rd_addr;

  logic [N:0]            lf;
  logic [ADDR_WIDTH-1:0] c_data [N];
  logic [ADDR_WIDTH-1:0] c_off  [N];
  logic [N-1:0]          c_en;

  logic [ADDR_WIDTH-1:0] o_data, o_off;
  logic                  o_en, last_free;

  int vectors = 0;
  int errors  = 0;

  assign lf[0] = 1'b0;

  for (genvar g = 0; g < N; g++) begin : g_cell
    object_cell #(.ID(g), .ADDR_WIDTH(ADDR_WIDTH), .HNDL_WIDTH(HNDL_WIDTH)) u_cell (
      .i_clock            (clk),
      .i_reset_n          (rst_n),
      .i_chip_select      (sel),
      .i_data             (din),
      .i_get_available_id (get_id),
      .i_write_to_map     (wr_map),
      .i_write_invalid    (wr_inv),
      .i_read_address     (rd_addr),
      .i_lower_free       (lf[g]),
      .o_lower_free       (lf[g+1]),
      .o_data             (c_data[g]),
      .o_data_en          (c_en[g]),
      .o_offset           (c_off[g])
    );
  end

  always_comb begin
    o_data = '0;
    o_off  = '0;
    for (int i = 0; i < N; i++) begin
      o_data = o_data | c_data[i];
      o_off  = o_off  | c_off[i];
    end
    o_en      = |c_en;
    last_free = lf[N];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    get_id = 0; wr_map = 0; wr_inv = 0; rd_addr = 0; din = '0; sel = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    @(negedge clk);
    clr();
    get_id = 1; rd_addr = 1; sel = 4'd0;
    #1;
    vectors++;
    if (o_data !== 16'h0 || o_en !== 1'b0) begin
      errors++; $display("FAIL reset_out: got data=%h en=%b, want 0000/0", o_data, o_en);
    end
    vectors++;
    if (o_off !== 16'h0 || last_free !== 1'b1) begin
      errors++; $display("FAIL reset_off: got off=%h lf=%b, want 0000/1", o_off, last_free);
    end
    @(negedge clk);
    clr();
    rst_n = 1;
  endtask

  task automatic test_alloc();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      clr(); get_id = 1;
      #1;
      vectors++;
      if (o_data !== 16'(i) || o_en !== 1'b1) begin
        errors++; $display("FAIL alloc_%0d: got data=%h en=%b, want %h/1", i, o_data, o_en, 16'(i));
      end
    end
    @(negedge clk);
    clr();
    #1;
    vectors++;
    if (last_free !== 1'b0) begin
      errors++; $display("FAIL chain_full: got lf=%b, want 0", last_free);
    end
    get_id = 1;
    #1;
    vectors++;
    if (o_en !== 1'b0 || o_data !== 16'h0) begin
      errors++; $display("FAIL alloc_none: got data=%h en=%b, want 0000/0", o_data, o_en);
    end
  endtask

  task automatic map_and_check(input logic [HNDL_WIDTH-1:0] s, input logic [ADDR_WIDTH-1:0] v,
                               input string tag);
    @(negedge clk);
    clr(); wr_map = 1; sel = s; din = v;
    @(negedge clk);
    clr(); sel = s;
    #1;
    vectors++;
    if (o_off !== v) begin
      errors++; $display("FAIL %s_off: got %h, want %h", tag, o_off, v);
    end
    rd_addr = 1;
    #1;
    vectors++;
    if (o_data !== v || o_en !== 1'b1) begin
      errors++; $display("FAIL %s_read: got data=%h en=%b, want %h/1", tag, o_data, o_en, v);
    end
  endtask

  task automatic test_map();
    map_and_check(4'd2, 16'h0010, "map2");
  endtask

  task automatic test_remap();
    map_and_check(4'd2, 16'h0006, "remap2");
  endtask

  task automatic test_free_realloc();
    @(negedge clk);
    clr(); wr_inv = 1; sel = 4'd2;
    @(negedge clk);
    clr(); rd_addr = 1; sel = 4'd2;
    #1;
    vectors++;
    if (o_en !== 1'b0 || o_off !== 16'h0) begin
      errors++; $display("FAIL freed_read: got en=%b off=%h, want 0/0000", o_en, o_off);
    end
    clr(); get_id = 1;
    #1;
    vectors++;
    if (o_data !== 16'h2 || o_en !== 1'b1) begin
      errors++; $display("FAIL realloc: got data=%h en=%b, want 0002/1", o_data, o_en);
    end
    @(negedge clk);
    clr(); sel = 4'd2;
    #1;
    vectors++;
    if (o_off !== 16'h0) begin
      errors++; $display("FAIL realloc_base: got %h, want 0000", o_off);
    end
  endtask

  task automatic test_map_free();
    @(negedge clk);
    clr(); wr_inv = 1; sel = 4'd3;
    @(negedge clk);
    clr(); wr_map = 1; sel = 4'd3; din = 16'h0020;
    @(negedge clk);
    clr(); sel = 4'd3;
    #1;
    vectors++;
    if (o_off !== 16'h0) begin
      errors++; $display("FAIL mapfree_off: got %h, want 0000", o_off);
    end
    rd_addr = 1;
    #1;
    vectors++;
    if (o_en !== 1'b0) begin
      errors++; $display("FAIL mapfree_read: got en=%b, want 0", o_en);
    end
  endtask

  task automatic test_reset_mid();
    map_and_check(4'd1, 16'h0044, "map1");
    #1;
    rst_n = 0;
    #1;
    vectors++;
    if (o_data !== 16'h0 || o_en !== 1'b0 || o_off !== 16'h0) begin
      errors++; $display("FAIL midreset_out: got data=%h en=%b off=%h, want 0000/0/0000",
                         o_data, o_en, o_off);
    end
    vectors++;
    if (last_free !== 1'b1) begin
      errors++; $display("FAIL midreset_lf: got %b, want 1", last_free);
    end
    @(negedge clk);
    clr();
    rst_n = 1;
    @(negedge clk);
    get_id = 1;
    #1;
    vectors++;
    if (o_data !== 16'h0 || o_en !== 1'b1) begin
      errors++; $display("FAIL post_reset_alloc: got data=%h en=%b, want 0000/1", o_data, o_en);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    clr(); get_id = 1;
    #1;
    vectors++;
    if (o_data !== 16'h1 || o_en !== 1'b1) begin
      errors++; $display("FAIL b2b_alloc: got data=%h en=%b, want 0001/1", o_data, o_en);
    end
    map_and_check(4'd0, 16'hBEEF, "b2b_map0");
    @(negedge clk);
    clr(); sel = 4'd1;
    #1;
    vectors++;
    if (o_off !== 16'h0) begin
      errors++; $display("FAIL b2b_off1: got %h, want 0000", o_off);
    end
  endtask

  initial begin
    clr();
    rst_n = 0;
    test_reset();
    test_alloc();
    test_map();
    test_remap();
    test_free_realloc();
    test_map_free();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
